// File: rtl/fifo_wr_arbiter_if.sv
// Write-side bus between the producers, the round-robin write arbiter and the FIFO.
// The arbiter connects through the slave modport; producers and the FIFO model use master.
interface fifo_wr_arbiter_if #(
    parameter int FIFO_WIDTH = 16,
    parameter int NUM_REQ    = 4
);
    localparam int IW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*FIFO_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            gnt;
    logic [NUM_REQ-1:0]            accept;
    logic [IW-1:0]                 owner;
    logic                          busy;
    logic                          fifo_wr_en;
    logic [FIFO_WIDTH-1:0]         fifo_data_in;
    logic                          fifo_full;
    logic                          fifo_overflow;
    logic                          err_overflow;

    modport slave (
        input  req, req_data, fifo_full, fifo_overflow,
        output gnt, accept, owner, busy, fifo_wr_en, fifo_data_in, err_overflow
    );

    modport master (
        output req, req_data, fifo_full, fifo_overflow,
        input  gnt, accept, owner, busy, fifo_wr_en, fifo_data_in, err_overflow
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers,
// granting bounded bursts of up to MAX_BURST words and never writing while full.
module fifo_wr_arbiter #(
    parameter int FIFO_WIDTH = 16,
    parameter int NUM_REQ    = 4,
    parameter int MAX_BURST  = 4
) (
    input  logic             clk,
    input  logic             rst,
    fifo_wr_arbiter_if.slave arb
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int BW = $clog2(MAX_BURST) + 1;
    localparam logic [IW-1:0]      LAST_IDX  = IW'(NUM_REQ - 1);
    localparam logic [BW-1:0]      LAST_BEAT = BW'(MAX_BURST - 1);
    localparam logic [NUM_REQ-1:0] ONE_HOT0  = NUM_REQ'(1);

    typedef enum logic {S_IDLE, S_BURST} state_t;

    state_t               state_q;
    logic [NUM_REQ-1:0]   gnt_q;
    logic [IW-1:0]        owner_q;
    logic [IW-1:0]        rr_ptr_q;
    logic [BW-1:0]        beat_cnt_q;
    logic                 busy_q;
    logic                 err_q;

    logic [IW-1:0]         sel_d;
    logic [IW-1:0]         next_ptr_d;
    logic                  any_req_d;
    logic                  own_req_d;
    logic                  wr_en_d;
    logic                  burst_done_d;
    logic [FIFO_WIDTH-1:0] data_d;

    // First requester at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        int            idx;
        logic [IW-1:0] idx_w;
        sel_d     = '0;
        any_req_d = 1'b0;
        idx       = 0;
        idx_w     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx   = (int'(rr_ptr_q) + k) % NUM_REQ;
            idx_w = IW'(idx);
            if (!any_req_d && arb.req[idx_w]) begin
                any_req_d = 1'b1;
                sel_d     = idx_w;
            end
        end
    end

    always_comb begin
        data_d = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (owner_q == IW'(k)) begin
                data_d = arb.req_data[k*FIFO_WIDTH +: FIFO_WIDTH];
            end
        end
    end

    assign own_req_d    = arb.req[owner_q];
    assign wr_en_d      = (state_q == S_BURST) && own_req_d && !arb.fifo_full;
    // A full stall keeps the owner's req high, so it never ends the burst.
    assign burst_done_d = (state_q == S_BURST) &&
                          ((wr_en_d && (beat_cnt_q == LAST_BEAT)) || !own_req_d);
    assign next_ptr_d   = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            gnt_q      <= '0;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            if (arb.fifo_overflow) begin
                err_q <= 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    if (any_req_d) begin
                        owner_q    <= sel_d;
                        gnt_q      <= ONE_HOT0 << sel_d;
                        beat_cnt_q <= '0;
                        busy_q     <= 1'b1;
                        state_q    <= S_BURST;
                    end
                end
                S_BURST: begin
                    if (wr_en_d) begin
                        beat_cnt_q <= beat_cnt_q + 1'b1;
                    end
                    if (burst_done_d) begin
                        gnt_q    <= '0;
                        busy_q   <= 1'b0;
                        rr_ptr_q <= next_ptr_d;
                        state_q  <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign arb.gnt          = gnt_q;
    assign arb.owner        = owner_q;
    assign arb.busy         = busy_q;
    assign arb.err_overflow = err_q;
    assign arb.fifo_wr_en   = wr_en_d;
    assign arb.fifo_data_in = data_d;
    assign arb.accept       = wr_en_d ? (ONE_HOT0 << owner_q) : '0;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: per-requester word queues and an
// expected burst list (owner, length) are filled as stimulus is queued.
module tb_fifo_wr_arbiter;
    localparam int W  = 16;
    localparam int N  = 4;
    localparam int MB = 4;

    typedef struct {
        int own;
        int len;
    } burst_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    fifo_wr_arbiter_if #(.FIFO_WIDTH(W), .NUM_REQ(N)) bus ();

    fifo_wr_arbiter #(.FIFO_WIDTH(W), .NUM_REQ(N), .MAX_BURST(MB)) dut (
        .clk (clk),
        .rst (rst),
        .arb (bus)
    );

    logic [W-1:0] src_q    [N][$];
    logic [W-1:0] exp_data [N][$];
    burst_t       exp_burst [$];
    bit           pending_pop [N];

    int n_chk = 0;
    int n_err = 0;
    bit mon_en   = 1'b0;
    bit in_burst = 1'b0;
    bit gap_pend = 1'b0;
    int idle_cnt  = 0;
    int acc_cnt   = 0;
    int burst_acc = 0;
    int cur_own   = 0;
    int cur_len   = 0;
    int stall_at  = -1;
    int stall_len = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic load(input int r, input int nwords);
        for (int k = 0; k < nwords; k++) begin
            logic [W-1:0] w;
            w = W'($urandom);
            src_q[r].push_back(w);
            exp_data[r].push_back(w);
        end
    endtask

    task automatic push_burst(input int own, input int len);
        burst_t b;
        b.own = own;
        b.len = len;
        exp_burst.push_back(b);
    endtask

    task automatic monitor();
        int     idx;
        burst_t b;
        idx = -1;
        if (bus.fifo_full) check_eq("wr_during_full", 32'(bus.fifo_wr_en), 0);
        if (!in_burst && bus.gnt != '0) begin
            if (exp_burst.size() == 0) begin
                check_eq("burst_expected", exp_burst.size(), 1);
                cur_own = -1;
                cur_len = -1;
            end else begin
                b = exp_burst.pop_front();
                cur_own = b.own;
                cur_len = b.len;
                check_eq("grant_owner", 32'(bus.owner), cur_own);
                check_eq("grant_onehot", 32'(bus.gnt), 1 << cur_own);
                check_eq("busy_start", 32'(bus.busy), 1);
            end
            if (gap_pend) check_eq("idle_gap", idle_cnt, 1);
            in_burst  = 1'b1;
            acc_cnt   = 0;
            burst_acc = 0;
            gap_pend  = 1'b0;
        end else if (in_burst && bus.gnt == '0) begin
            check_eq("burst_len", acc_cnt, cur_len);
            check_eq("busy_end", 32'(bus.busy), 0);
            in_burst = 1'b0;
            idle_cnt = 1;
            gap_pend = (bus.req != '0);
        end else if (!in_burst) begin
            idle_cnt++;
        end
        if (in_burst && bus.fifo_full) check_eq("stall_gnt", 32'(bus.gnt), 1 << cur_own);
        if (bus.accept != '0) begin
            check_eq("acc_onehot", $countones(bus.accept), 1);
            for (int i = 0; i < N; i++) if (bus.accept[i]) idx = i;
            check_eq("acc_owner", idx, cur_own);
            check_eq("acc_wr_en", 32'(bus.fifo_wr_en), 1);
            if (exp_data[idx].size() > 0)
                check_eq("data", 32'(bus.fifo_data_in), 32'(exp_data[idx].pop_front()));
            else
                check_eq("data_queued", exp_data[idx].size(), 1);
            acc_cnt++;
            burst_acc++;
            pending_pop[idx] = 1'b1;
        end else begin
            check_eq("wr_without_accept", 32'(bus.fifo_wr_en), 0);
        end
    endtask

    // Producers and FIFO-full model: inputs change on negedge, outputs sampled 1 later.
    initial begin
        bus.req       = '0;
        bus.req_data  = '0;
        bus.fifo_full = 1'b0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (pending_pop[i]) begin
                    if (src_q[i].size() > 0) void'(src_q[i].pop_front());
                    pending_pop[i] = 1'b0;
                end
            end
            if (stall_len > 0 && in_burst && burst_acc == stall_at) begin
                bus.fifo_full = 1'b1;
                stall_len--;
            end else begin
                bus.fifo_full = 1'b0;
            end
            for (int i = 0; i < N; i++) begin
                bus.req[i] = (src_q[i].size() > 0);
                bus.req_data[i*W +: W] = (src_q[i].size() > 0) ? src_q[i][0] : '0;
            end
            #1;
            if (mon_en) monitor();
        end
    end

    task automatic wait_drain(input int limit);
        bit done;
        done = 1'b0;
        for (int n = 0; n < limit && !done; n++) begin
            @(negedge clk);
            #2;
            done = !in_burst && exp_burst.size() == 0;
            for (int i = 0; i < N; i++) if (src_q[i].size() != 0) done = 1'b0;
        end
        check_eq("drain", 32'(done), 1);
    endtask

    initial begin
        bit seen;
        rst = 1'b1;
        bus.fifo_overflow = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        check_eq("rst_gnt", 32'(bus.gnt), 0);
        check_eq("rst_busy", 32'(bus.busy), 0);
        check_eq("rst_owner", 32'(bus.owner), 0);
        check_eq("rst_accept", 32'(bus.accept), 0);
        check_eq("rst_wr_en", 32'(bus.fifo_wr_en), 0);
        check_eq("rst_err", 32'(bus.err_overflow), 0);
        rst = 1'b0;
        @(negedge clk);
        #2;
        mon_en = 1'b1;

        // single requester, 10 words -> 4,4,2
        push_burst(2, 4); push_burst(2, 4); push_burst(2, 2);
        load(2, 10);
        wait_drain(200);

        // all four requesting, rr_ptr starts at 3
        for (int r = 0; r < 2; r++) begin
            push_burst(3, 4); push_burst(0, 4); push_burst(1, 4); push_burst(2, 4);
        end
        for (int i = 0; i < N; i++) load(i, 8);
        wait_drain(300);

        // full stall after two accepts
        stall_at  = 2;
        stall_len = 5;
        push_burst(1, 4);
        load(1, 4);
        wait_drain(200);
        check_eq("stall_consumed", stall_len, 0);
        stall_at = -1;

        // early release of requester 3; rr_ptr must then be 0
        push_burst(3, 1); push_burst(0, 2); push_burst(1, 2);
        load(3, 1); load(0, 2); load(1, 2);
        wait_drain(200);

        // sticky overflow flag
        @(negedge clk);
        #2;
        check_eq("err_before", 32'(bus.err_overflow), 0);
        bus.fifo_overflow = 1'b1;
        @(negedge clk);
        #2;
        bus.fifo_overflow = 1'b0;
        check_eq("err_set", 32'(bus.err_overflow), 1);
        repeat (5) @(negedge clk);
        #2;
        check_eq("err_hold", 32'(bus.err_overflow), 1);

        // reset in the middle of a burst
        push_burst(2, 4);
        load(2, 4);
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            #2;
            seen = bus.fifo_wr_en;
        end
        check_eq("rst_wr_seen", 32'(seen), 1);
        mon_en = 1'b0;
        rst = 1'b1;
        #1;
        check_eq("mid_rst_wr_en", 32'(bus.fifo_wr_en), 0);
        check_eq("mid_rst_gnt", 32'(bus.gnt), 0);
        check_eq("mid_rst_busy", 32'(bus.busy), 0);
        check_eq("mid_rst_accept", 32'(bus.accept), 0);
        check_eq("mid_rst_err", 32'(bus.err_overflow), 0);
        for (int i = 0; i < N; i++) begin
            src_q[i].delete();
            exp_data[i].delete();
            pending_pop[i] = 1'b0;
        end
        exp_burst.delete();
        in_burst = 1'b0;
        gap_pend = 1'b0;
        idle_cnt = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #2;
        check_eq("post_rst_owner", 32'(bus.owner), 0);
        check_eq("post_rst_gnt", 32'(bus.gnt), 0);
        mon_en = 1'b1;

        // rr_ptr back at 0: requester 1 wins over 2
        push_burst(1, 2); push_burst(2, 3);
        load(2, 3); load(1, 2);
        wait_drain(200);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", n_chk, n_err);
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-port arbiter that shares the single write port of the synchronous FIFO among NUM_REQ producers. A requester wins a grant and writes a bounded burst of up to MAX_BURST words. The arbiter never issues a write while the FIFO reports full. It sits directly in front of the FIFO write side, driving its wr_en and data_in and observing its full and overflow flags.

## Interface
Parameters:
- FIFO_WIDTH, 16: data word width; must match the FIFO.
- NUM_REQ, 4: number of requesters, 2..8.
- MAX_BURST, 4: maximum accepted words per grant, 1..16.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- req  in  NUM_REQ  per-requester write request; held with stable data until accept.
- req_data  in  NUM_REQ*FIFO_WIDTH  requester i word on slice [i*FIFO_WIDTH +: FIFO_WIDTH].
- gnt  out  NUM_REQ  registered one-hot grant; all-zero when idle.
- accept  out  NUM_REQ  combinational; bit i high means requester i's word is written this cycle.
- owner  out  $clog2(NUM_REQ)  registered index of the current or last grantee.
- busy  out  1  registered; high in BURST.
- fifo_wr_en  out  1  combinational write enable to the FIFO.
- fifo_data_in  out  FIFO_WIDTH  combinational; the owner's req_data slice.
- fifo_full  in  1  FIFO full flag.
- fifo_overflow  in  1  FIFO overflow flag.
- err_overflow  out  1  sticky; set whenever fifo_overflow is sampled high.

## Operation
- State machine has two states: IDLE and BURST.
- Internal registers:
  - rr_ptr: $clog2(NUM_REQ) bits; the highest-priority index.
  - beat_cnt: $clog2(MAX_BURST)+1 bits.
- IDLE:
  - If any req bit is set, select the first set bit scanning rr_ptr, rr_ptr+1, … with modulo-NUM_REQ wrap.
  - At the next edge: owner <= selected, gnt <= onehot(selected), beat_cnt <= 0, state <= BURST.
  - No write occurs in IDLE.
- BURST:
  - fifo_wr_en = req[owner] && !fifo_full.
  - accept = fifo_wr_en ? onehot(owner) : 0.
  - fifo_data_in = req_data slice of owner, always driven.
  - Each accept increments beat_cnt.
- Burst end, evaluated each BURST edge. State returns to IDLE, gnt <= 0, and rr_ptr <= (owner+1) mod NUM_REQ when either:
  - an accept occurs with beat_cnt == MAX_BURST-1, or
  - req[owner] is low (no accept that cycle).
- Full stall: while fifo_full is high, the grant is held and beat_cnt is frozen. Stalls do not consume burst budget.
- Non-owner req bits are ignored during BURST. They are never accepted.
- err_overflow is set and held until reset. In correct operation it never sets.
- Reset values: state IDLE, gnt 0, owner 0, busy 0, rr_ptr 0, beat_cnt 0, err_overflow 0. Consequently fifo_wr_en 0 and accept 0.

## Timing
- Request-to-first-write latency: a req sampled high at edge N in IDLE gives gnt after edge N. The first accept is possible in the cycle following edge N.
- Burst length: exactly min(MAX_BURST, words offered while req held) accepts.
- Gap between bursts: one IDLE cycle. Peak throughput is MAX_BURST/(MAX_BURST+1) words/cycle.
- Handshake: a requester keeps req and data stable until it sees accept high at a posedge. It may drop req the cycle after the accept.
- Write timing: fifo_wr_en is never high in a cycle where fifo_full is high.
- Simultaneous events:
  - If the owner's burst ends and other requests are pending, arbitration happens in the following IDLE cycle using the updated rr_ptr.
  - A single requester re-asserting wins back-to-back bursts with one idle cycle between.
- Reset mid-burst: state clears immediately (asynchronous). fifo_wr_en and accept drop in the same cycle. Any partially written burst is not resumed.
- Wrap-around: rr_ptr and the scan wrap modulo NUM_REQ; owner NUM_REQ-1 rolls rr_ptr to 0.

## Test plan
- Reset: assert rst mid-burst with fifo_wr_en high -> fifo_wr_en, gnt, busy, accept, and err_overflow all 0 immediately; owner 0 after release.
- Single requester: req[2]=1 held with 10 words, MAX_BURST=4 -> accepts in groups of 4,4,2, one idle cycle between groups. fifo_data_in matches the sequence; owner=2 throughout.
- Fairness: req=4'b1111 held continuously -> grant order 0,1,2,3,0…, each burst 4 words, no requester starved.
- Full stall: grant req[1], then fifo_full=1 for 5 cycles after 2 accepts -> no fifo_wr_en during the stall; gnt held; the burst completes the remaining 2 words after full drops.
- Early release: req[3] drops after 1 accept -> busy falls at the next edge and rr_ptr=0. A pending req[0] is granted after one idle cycle.
- Overflow flag: force fifo_overflow=1 for one cycle -> err_overflow rises at the next edge and stays 1 until rst.
